victim_cache_ctl: RTL
=====================

// Module: victim_cache_ctl
// PURPOSE
//  Parametrised, self-controlled, fully associative victim cache between L1 and L2.
//  - Absorbs lines evicted by L1 and serves L1 misses that hit a held victim (swap-out).
//  - Writes dirty lines back to L2 when they are displaced, or on flush.
//  - Merges the former split datapath/control pair into one block and adds age-based
//    LRU, a flush mode and a configurable way count.
// PARAMETERS
//  WAYS    4    number of fully associative entries; power of two, 2..16
//  ADDR_W  16   byte address width
//  OFF_W   4    line offset bits; tag = ADDR_W-OFF_W bits
//  LINE_W  128  line width in bits
// PORTS
//  clk            in   1       single clock; all state updates on posedge
//  rst            in   1       synchronous, active-high reset
//  lk_req         in   1       L1 miss lookup request; held until lk_resp
//  lk_address     in   ADDR_W  lookup address; offset bits ignored
//  lk_resp        out  1       one-cycle pulse: lookup complete
//  lk_hit         out  1       qualifies lk_resp: line found, lk_rdata valid
//  lk_rdata       out  LINE_W  hit line
//  lk_rdirty      out  1       dirty bit of hit line (L1 inherits it)
//  ev_valid       in   1       L1 presents an evicted line
//  ev_address     in   ADDR_W  evicted line address
//  ev_data        in   LINE_W  evicted line
//  ev_dirty       in   1       evicted line dirty
//  ev_ready       out  1       evicted line accepted when ev_valid & ev_ready
//  flush          in   1       pulse: write back every dirty entry, then invalidate all
//  flush_done     out  1       one-cycle pulse at end of flush
//  pmem_write     out  1       L2 write request; held until pmem_resp
//  pmem_address   out  ADDR_W  {tag, OFF_W'b0} of line being written back
//  pmem_wdata     out  LINE_W  line being written back
//  pmem_resp      in   1       L2 write complete
// BEHAVIOUR
//  Reset: all valid/dirty/age cleared; FSM -> IDLE; every output 0 except ev_ready=1.
//  FSM states: IDLE, LK_RESP, WB, INSERT, FLUSH_SCAN, FLUSH_WB.
//  IDLE, priority flush > lk_req > ev_valid:
//  - lk_req: tag compare over all ways in the same cycle -> LK_RESP.
//    On hit, the matching way is invalidated in that transition (line moves to L1).
//  - ev_valid: ev_ready=1 in IDLE only; accept, then go to INSERT or WB (see victim select).
//  LK_RESP: lk_resp=1 for exactly one cycle with lk_hit/lk_rdata/lk_rdirty. Miss: lk_hit=0,
//   lk_rdata=0. Latency request->resp = 2 cycles. Returns to IDLE.
//  Victim select, at ev accept, evaluated in order:
//   1. way whose valid tag equals the ev tag (overwrite, dirty = old|new);
//   2. lowest-index invalid way;
//   3. way with max age (ties -> lowest index).
//   If the chosen way is valid, dirty and not a tag match -> WB; else -> INSERT.
//  WB: pmem_write=1 with the chosen way's address/data, stable until pmem_resp.
//   Then -> INSERT. Clean displaced lines are dropped silently.
//  INSERT: write tag/data/dirty, valid=1; new line age=0; other valid ways age+1,
//   saturating at WAYS-1. -> IDLE. ev_ready low from accept until back in IDLE.
//   A lookup hit also clears the way's age.
//  FLUSH_SCAN: lowest-index valid dirty way -> FLUSH_WB; none left -> invalidate all,
//   flush_done=1, -> IDLE.
//  FLUSH_WB: as WB; on pmem_resp clear that way's dirty bit -> FLUSH_SCAN.
//   lk_req and ev_valid are stalled (no resp, ev_ready=0) during flush.
//  Simultaneous lk_req & ev_valid: lookup first, eviction accepted on the next IDLE cycle.
//   If the same line is in both, the hit is served before insert; no duplicate entries.
//  rst asserted mid-WB/FLUSH_WB: pmem_write drops the next cycle; the L2 transaction is
//   abandoned and contents are lost.
//  pmem_resp outside WB/FLUSH_WB is ignored.
// STRUCTURE
//  cache_types package additions:
//   - victim_state_e enum;
//   - localparam helpers for tag width and way-index width ($clog2(WAYS)).
//  Sub-module victim_age_lru: per-way age counters, insert/touch/invalidate inputs,
//   combinational victim index output.
//  Tag/data/valid/dirty storage is an array of regs in this module; no SRAM macro.
// TESTING
//  1. Reset, then lk_req 0x1230 -> lk_resp after 2 cycles, lk_hit=0; ev_ready=1.
//  2. Evict 0x1230 (clean, data A), lookup 0x1236 -> lk_hit=1, lk_rdata=A.
//     Repeat the lookup -> lk_hit=0 (entry invalidated).
//  3. Fill 4 ways with 0x1000..0x1030, way0 dirty; evict 0x2000
//     -> pmem_write with pmem_address=0x1000 and way0 data held through 3 stall cycles
//     until pmem_resp; 0x2000 then resident.
//  4. Fill 4 clean ways, evict 0x5000 -> no pmem_write; 0x1000 (oldest) displaced.
//  5. Ways 1 and 3 dirty, flush -> two writebacks in index order, flush_done pulse,
//     all lookups miss afterwards.
//  6. rst asserted on the 2nd cycle of WB -> pmem_write=0 the next cycle,
//     all entries invalid, ev_ready=1.

Source files
------------

// File: rtl/victim_cache_ctl_pkg.sv
// rtl/victim_cache_ctl_pkg.sv - shared types and width helpers for the victim cache
// Purpose: FSM state encoding and width helpers used by victim_cache_ctl and victim_age_lru.
// Ports: none (package).
package victim_cache_ctl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LK_RESP,
        S_WB,
        S_INSERT,
        S_FLUSH_SCAN,
        S_FLUSH_WB
    } victim_state_e;

    localparam int DEF_WAYS   = 4;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_OFF_W  = 4;
    localparam int DEF_LINE_W = 128;

    // Tag is everything above the line offset.
    function automatic int tag_width(input int addr_w, input int off_w);
        return addr_w - off_w;
    endfunction

    // Way index width; never below one bit so index vectors stay legal.
    function automatic int idx_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/victim_age_lru.sv
// rtl/victim_age_lru.sv - per-way age counters and oldest-way selection
// Purpose: ages every valid way on each insert, clears age on insert/touch/flush,
//          and reports the oldest way (ties resolved to the lowest index).
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   valid_i          per-way valid vector (only valid ways age)
//   ins_i/ins_way_i  insert event: chosen way age 0, other valid ways +1 (saturating)
//   clr_i/clr_way_i  touch event: clear one way's age
//   clr_all_i        clear every age
//   victim_o         index of the way with the greatest age
module victim_age_lru
    import victim_cache_ctl_pkg::*;
#(
    parameter int WAYS  = DEF_WAYS,
    parameter int IDX_W = idx_width(DEF_WAYS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WAYS-1:0]  valid_i,
    input  logic             ins_i,
    input  logic [IDX_W-1:0] ins_way_i,
    input  logic             clr_i,
    input  logic [IDX_W-1:0] clr_way_i,
    input  logic             clr_all_i,
    output logic [IDX_W-1:0] victim_o
);

    localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(WAYS - 1);

    logic [IDX_W-1:0] age_q [WAYS];
    logic [IDX_W-1:0] age_d [WAYS];
    logic [IDX_W-1:0] best;

    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            age_d[i] = age_q[i];
            if (ins_i) begin
                if (ins_way_i == IDX_W'(i)) begin
                    age_d[i] = '0;
                end else if (valid_i[i] && age_q[i] != AGE_MAX) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end
            if (clr_i && clr_way_i == IDX_W'(i)) begin
                age_d[i] = '0;
            end
            if (clr_all_i) begin
                age_d[i] = '0;
            end
        end
    end

    // Strict greater-than keeps the first (lowest-index) way on ties.
    always_comb begin
        victim_o = '0;
        best     = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (age_q[i] > best) begin
                best     = age_q[i];
                victim_o = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < WAYS; i++) begin
            if (rst_i) begin
                age_q[i] <= '0;
            end else begin
                age_q[i] <= age_d[i];
            end
        end
    end

endmodule

// File: rtl/victim_cache_ctl.sv
// rtl/victim_cache_ctl.sv - fully associative victim cache controller between L1 and L2
// Purpose: holds L1 evictions, serves L1 miss lookups (hit moves the line back to L1),
//          writes displaced dirty lines to L2, and flushes all dirty lines on request.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   lk_req/lk_address             lookup request (held until lk_resp)
//   lk_resp/lk_hit/lk_rdata/lk_rdirty  one-cycle lookup response
//   ev_valid/ev_address/ev_data/ev_dirty/ev_ready  eviction handshake from L1
//   flush/flush_done              flush pulse in, completion pulse out
//   pmem_write/pmem_address/pmem_wdata/pmem_resp   L2 writeback port
module victim_cache_ctl
    import victim_cache_ctl_pkg::*;
#(
    parameter int WAYS   = DEF_WAYS,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int OFF_W  = DEF_OFF_W,
    parameter int LINE_W = DEF_LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lk_req,
    input  logic [ADDR_W-1:0] lk_address,
    output logic              lk_resp,
    output logic              lk_hit,
    output logic [LINE_W-1:0] lk_rdata,
    output logic              lk_rdirty,
    input  logic              ev_valid,
    input  logic [ADDR_W-1:0] ev_address,
    input  logic [LINE_W-1:0] ev_data,
    input  logic              ev_dirty,
    output logic              ev_ready,
    input  logic              flush,
    output logic              flush_done,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp
);

    localparam int TAG_W = tag_width(ADDR_W, OFF_W);
    localparam int IDX_W = idx_width(WAYS);

    victim_state_e     state_q, state_d;
    logic [WAYS-1:0]   valid_q, valid_d;
    logic [WAYS-1:0]   dirty_q, dirty_d;
    logic [TAG_W-1:0]  tag_q  [WAYS];
    logic [LINE_W-1:0] data_q [WAYS];
    logic [IDX_W-1:0]  way_q, way_d;
    logic [TAG_W-1:0]  ev_tag_q, ev_tag_d;
    logic [LINE_W-1:0] ev_data_q, ev_data_d;
    logic              ev_dirty_q, ev_dirty_d;
    logic              ev_match_q, ev_match_d;
    logic              hit_q, hit_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              rdirty_q, rdirty_d;

    logic [TAG_W-1:0]  lk_tag, ev_tag;
    logic              lk_hit_c, ev_match_c, free_c, dirty_c, ev_wb_c;
    logic [IDX_W-1:0]  lk_way_c, ev_match_way_c, free_way_c, dirty_way_c, ev_way_c;
    logic [IDX_W-1:0]  lru_victim, lru_clr_way;
    logic              lru_clr, lru_clr_all, wr_en;
    logic              unused_offsets;

    assign lk_tag         = lk_address[ADDR_W-1:OFF_W];
    assign ev_tag         = ev_address[ADDR_W-1:OFF_W];
    assign unused_offsets = ^{lk_address[OFF_W-1:0], ev_address[OFF_W-1:0]};

    // Descending scan so the lowest matching index is the one that sticks.
    always_comb begin
        lk_hit_c       = 1'b0;
        lk_way_c       = '0;
        ev_match_c     = 1'b0;
        ev_match_way_c = '0;
        free_c         = 1'b0;
        free_way_c     = '0;
        dirty_c        = 1'b0;
        dirty_way_c    = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (valid_q[i] && tag_q[i] == lk_tag) begin
                lk_hit_c = 1'b1;
                lk_way_c = IDX_W'(i);
            end
            if (valid_q[i] && tag_q[i] == ev_tag) begin
                ev_match_c     = 1'b1;
                ev_match_way_c = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                free_c     = 1'b1;
                free_way_c = IDX_W'(i);
            end
            if (valid_q[i] && dirty_q[i]) begin
                dirty_c     = 1'b1;
                dirty_way_c = IDX_W'(i);
            end
        end
    end

    // A writeback is only needed when a valid dirty line of a different tag is displaced,
    // which can only happen when every way is valid (the LRU pick).
    assign ev_way_c = ev_match_c ? ev_match_way_c : (free_c ? free_way_c : lru_victim);
    assign ev_wb_c  = !ev_match_c && !free_c && dirty_q[lru_victim];

    victim_age_lru #(
        .WAYS  (WAYS),
        .IDX_W (IDX_W)
    ) u_age_lru (
        .clk_i     (clk),
        .rst_i     (rst),
        .valid_i   (valid_q),
        .ins_i     (state_q == S_INSERT),
        .ins_way_i (way_q),
        .clr_i     (lru_clr),
        .clr_way_i (lru_clr_way),
        .clr_all_i (lru_clr_all),
        .victim_o  (lru_victim)
    );

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        way_d        = way_q;
        ev_tag_d     = ev_tag_q;
        ev_data_d    = ev_data_q;
        ev_dirty_d   = ev_dirty_q;
        ev_match_d   = ev_match_q;
        hit_d        = hit_q;
        rdata_d      = rdata_q;
        rdirty_d     = rdirty_q;
        lru_clr      = 1'b0;
        lru_clr_way  = lk_way_c;
        lru_clr_all  = 1'b0;
        wr_en        = 1'b0;
        lk_resp      = 1'b0;
        lk_hit       = 1'b0;
        lk_rdata     = '0;
        lk_rdirty    = 1'b0;
        ev_ready     = 1'b0;
        flush_done   = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;

        case (state_q)
            S_IDLE: begin
                // Ready only when the eviction would actually be taken this cycle.
                ev_ready = !flush && !lk_req;
                if (flush) begin
                    state_d = S_FLUSH_SCAN;
                end else if (lk_req) begin
                    hit_d    = lk_hit_c;
                    rdata_d  = lk_hit_c ? data_q[lk_way_c] : '0;
                    rdirty_d = lk_hit_c && dirty_q[lk_way_c];
                    if (lk_hit_c) begin
                        // Line moves to L1, so the entry is released immediately.
                        valid_d[lk_way_c] = 1'b0;
                        dirty_d[lk_way_c] = 1'b0;
                        lru_clr           = 1'b1;
                    end
                    state_d = S_LK_RESP;
                end else if (ev_valid) begin
                    way_d      = ev_way_c;
                    ev_tag_d   = ev_tag;
                    ev_data_d  = ev_data;
                    ev_dirty_d = ev_dirty;
                    ev_match_d = ev_match_c;
                    state_d    = ev_wb_c ? S_WB : S_INSERT;
                end
            end
            S_LK_RESP: begin
                lk_resp   = 1'b1;
                lk_hit    = hit_q;
                lk_rdata  = rdata_q;
                lk_rdirty = rdirty_q;
                state_d   = S_IDLE;
            end
            S_WB: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[way_q], {OFF_W{1'b0}}};
                pmem_wdata   = data_q[way_q];
                if (pmem_resp) begin
                    state_d = S_INSERT;
                end
            end
            S_INSERT: begin
                wr_en          = 1'b1;
                valid_d[way_q] = 1'b1;
                dirty_d[way_q] = ev_dirty_q || (ev_match_q && dirty_q[way_q]);
                state_d        = S_IDLE;
            end
            S_FLUSH_SCAN: begin
                if (dirty_c) begin
                    way_d   = dirty_way_c;
                    state_d = S_FLUSH_WB;
                end else begin
                    valid_d     = '0;
                    dirty_d     = '0;
                    lru_clr_all = 1'b1;
                    flush_done  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_FLUSH_WB: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[way_q], {OFF_W{1'b0}}};
                pmem_wdata   = data_q[way_q];
                if (pmem_resp) begin
                    dirty_d[way_q] = 1'b0;
                    state_d        = S_FLUSH_SCAN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            way_q      <= '0;
            ev_tag_q   <= '0;
            ev_data_q  <= '0;
            ev_dirty_q <= 1'b0;
            ev_match_q <= 1'b0;
            hit_q      <= 1'b0;
            rdata_q    <= '0;
            rdirty_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            way_q      <= way_d;
            ev_tag_q   <= ev_tag_d;
            ev_data_q  <= ev_data_d;
            ev_dirty_q <= ev_dirty_d;
            ev_match_q <= ev_match_d;
            hit_q      <= hit_d;
            rdata_q    <= rdata_d;
            rdirty_q   <= rdirty_d;
        end
    end

    // Line storage needs no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[way_q]  <= ev_tag_q;
            data_q[way_q] <= ev_data_q;
        end
    end

endmodule
